// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and global hold.
// Optional load-use bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [12:0]   ID_Ctrl,
    input  logic [DW-1:0] ID_PC4,
    input  logic [DW-1:0] ID_RD1,
    input  logic [DW-1:0] ID_RD2,
    input  logic [DW-1:0] ID_Imm,
    input  logic [RW-1:0] ID_Rs,
    input  logic [RW-1:0] ID_Rt,
    input  logic [RW-1:0] ID_Rd,
    input  logic          ID_Flush_Branch,
    input  logic          Hold,
    output logic [12:0]   EX_Ctrl,
    output logic [DW-1:0] EX_PC4,
    output logic [DW-1:0] EX_RD1,
    output logic [DW-1:0] EX_RD2,
    output logic [DW-1:0] EX_Imm,
    output logic [RW-1:0] EX_Rs,
    output logic [RW-1:0] EX_Rt,
    output logic [RW-1:0] EX_Rd,
    output logic          LoadUse,
    output logic          PCWrite,
    output logic          IFID_Write,
    output logic [15:0]   BubbleCount
);
    localparam int MEMREAD_BIT = 8;

    logic ex_mem_read;
    logic rt_nonzero;
    logic rt_match;
    logic advance;
    logic kill_ctrl;

    assign ex_mem_read = EX_Ctrl[MEMREAD_BIT];
    assign rt_nonzero  = (EX_Rt != '0);
    assign rt_match    = (EX_Rt == ID_Rs) || (EX_Rt == ID_Rt);
    assign LoadUse     = ex_mem_read && rt_nonzero && rt_match;

    // A flush wins over a stall so the redirect from MEM is actually taken.
    assign advance    = !Hold && (ID_Flush_Branch || !LoadUse);
    assign PCWrite    = advance;
    assign IFID_Write = advance;

    assign kill_ctrl = ID_Flush_Branch || LoadUse;

    always_ff @(posedge clk) begin
        if (reset) begin
            EX_Ctrl <= '0;
            EX_PC4  <= '0;
            EX_RD1  <= '0;
            EX_RD2  <= '0;
            EX_Imm  <= '0;
            EX_Rs   <= '0;
            EX_Rt   <= '0;
            EX_Rd   <= '0;
        end else if (!Hold) begin
            EX_Ctrl <= kill_ctrl ? 13'd0 : ID_Ctrl;
            EX_PC4  <= ID_PC4;
            EX_RD1  <= ID_RD1;
            EX_RD2  <= ID_RD2;
            EX_Imm  <= ID_Imm;
            EX_Rs   <= ID_Rs;
            EX_Rt   <= ID_Rt;
            EX_Rd   <= ID_Rd;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;
    logic        count_bubble;

    // Only load-use bubbles are counted; flush bubbles and held cycles are not.
    assign count_bubble = !Hold && !ID_Flush_Branch && LoadUse;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_reg <= '0;
        end else if (count_bubble && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign BubbleCount = bubble_cnt_reg;
`else
    assign BubbleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model compared every cycle plus directed literal checks.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [12:0] LW_CTRL  = 13'h1118;
    localparam logic [12:0] ADD_CTRL = 13'h040A;

    logic          clk = 1'b0;
    logic          reset;
    logic [12:0]   ID_Ctrl;
    logic [DW-1:0] ID_PC4, ID_RD1, ID_RD2, ID_Imm;
    logic [RW-1:0] ID_Rs, ID_Rt, ID_Rd;
    logic          ID_Flush_Branch, Hold;
    logic [12:0]   EX_Ctrl;
    logic [DW-1:0] EX_PC4, EX_RD1, EX_RD2, EX_Imm;
    logic [RW-1:0] EX_Rs, EX_Rt, EX_Rd;
    logic          LoadUse, PCWrite, IFID_Write;
    logic [15:0]   BubbleCount;

    int total = 0;
    int bad = 0;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset),
        .ID_Ctrl(ID_Ctrl), .ID_PC4(ID_PC4), .ID_RD1(ID_RD1), .ID_RD2(ID_RD2),
        .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_Flush_Branch(ID_Flush_Branch), .Hold(Hold),
        .EX_Ctrl(EX_Ctrl), .EX_PC4(EX_PC4), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2),
        .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .LoadUse(LoadUse), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the EX-side instruction as seen by the pipeline.
    logic          m_valid = 1'b0;
    logic [12:0]   m_ctrl;
    logic [DW-1:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [RW-1:0] m_rs, m_rt, m_rd;
    int            m_bubbles;

    function automatic bit model_hazard();
        // EX is a load writing a real register that the ID instruction reads.
        return m_ctrl[8] && m_rt != 0 && (m_rt == ID_Rs || m_rt == ID_Rt);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            {m_ctrl, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} = '0;
            m_bubbles = 0;
        end else if (m_valid && !Hold) begin
            if (!ID_Flush_Branch && model_hazard() && m_bubbles < 65535)
                m_bubbles = m_bubbles + 1;
            m_ctrl = (ID_Flush_Branch || model_hazard()) ? 13'd0 : ID_Ctrl;
            m_pc4 = ID_PC4; m_rd1 = ID_RD1; m_rd2 = ID_RD2; m_imm = ID_Imm;
            m_rs = ID_Rs; m_rt = ID_Rt; m_rd = ID_Rd;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic exp_en;
            exp_en = !Hold && (ID_Flush_Branch || !model_hazard());
            chk("ctrl", 64'(EX_Ctrl), 64'(m_ctrl));
            chk("pc4", 64'(EX_PC4), 64'(m_pc4));
            chk("rd1", 64'(EX_RD1), 64'(m_rd1));
            chk("rd2", 64'(EX_RD2), 64'(m_rd2));
            chk("imm", 64'(EX_Imm), 64'(m_imm));
            chk("rs", 64'(EX_Rs), 64'(m_rs));
            chk("rt", 64'(EX_Rt), 64'(m_rt));
            chk("rd", 64'(EX_Rd), 64'(m_rd));
            chk("loaduse", 64'(LoadUse), 64'(model_hazard()));
            chk("pcwrite", 64'(PCWrite), 64'(exp_en));
            chk("ifid_write", 64'(IFID_Write), 64'(exp_en));
`ifdef ID_EX_BUBBLE_CNT_EN
            chk("bubbles", 64'(BubbleCount), 64'(m_bubbles));
`else
            chk("bubbles", 64'(BubbleCount), 64'(0));
`endif
        end
    end

    task automatic set_id(input logic [12:0] c, input logic [31:0] rd1, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ID_Ctrl = c; ID_RD1 = rd1; ID_RD2 = rd1 ^ 32'h5A5A_0000; ID_Imm = imm;
        ID_PC4 = {rd1[29:0], 2'b00} + 32'd4; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    endtask

    // Advance one edge; inputs change shortly after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic note(input string s);
        $display("txn %0t: %s ctrl=%0h rt=%0d lu=%0b pcw=%0b bc=%0d", $time, s, EX_Ctrl, EX_Rt,
                 LoadUse, PCWrite, BubbleCount);
    endtask

    initial begin
        reset = 1'b1; Hold = 1'b0; ID_Flush_Branch = 1'b0;
        set_id(13'h1FFF, 32'hDEAD_BEEF, 32'h1234, 5'd7, 5'd8, 5'd9);
        tick(); tick();
        #1;
        chk("lit_reset_ctrl", 64'(EX_Ctrl), 64'h0);
        chk("lit_reset_rd1", 64'(EX_RD1), 64'h0);
        chk("lit_reset_pcw", 64'(PCWrite), 64'h1);
        chk("lit_reset_bc", 64'(BubbleCount), 64'h0);
        note("reset");

        // Pass-through
        reset = 1'b0;
        set_id(13'h1AC0, 32'h10, 32'h4, 5'd3, 5'd8, 5'd0);
        tick(); #1;
        chk("lit_pass_ctrl", 64'(EX_Ctrl), 64'h1AC0);
        chk("lit_pass_rd1", 64'(EX_RD1), 64'h10);
        chk("lit_pass_imm", 64'(EX_Imm), 64'h4);
        chk("lit_pass_rt", 64'(EX_Rt), 64'd8);
        note("pass");

        // Load-use: lw $8 then add using $8
        set_id(LW_CTRL, 32'h100, 32'h8, 5'd1, 5'd8, 5'd0);
        tick();
        set_id(ADD_CTRL, 32'h22, 32'h0, 5'd8, 5'd9, 5'd10);
        #1;
        chk("lit_lu_flag", 64'(LoadUse), 64'h1);
        chk("lit_lu_pcw", 64'(PCWrite), 64'h0);
        chk("lit_lu_ifid", 64'(IFID_Write), 64'h0);
        note("loaduse");
        tick(); #1;
        chk("lit_bubble_ctrl", 64'(EX_Ctrl), 64'h0);
        chk("lit_bubble_lu", 64'(LoadUse), 64'h0);
        note("bubble");
        tick(); #1;
        chk("lit_add_ctrl", 64'(EX_Ctrl), 64'(ADD_CTRL));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("lit_bc_one", 64'(BubbleCount), 64'h1);
`endif
        note("add in EX");

        // $zero never hazards
        set_id(LW_CTRL, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0);
        tick();
        set_id(ADD_CTRL, 32'h1, 32'h0, 5'd0, 5'd5, 5'd6);
        #1;
        chk("lit_zero_lu", 64'(LoadUse), 64'h0);
        note("zero");
        // No-match and rt-match
        set_id(LW_CTRL, 32'h30, 32'h0, 5'd2, 5'd8, 5'd0);
        tick();
        set_id(ADD_CTRL, 32'h2, 32'h0, 5'd9, 5'd10, 5'd11);
        #1;
        chk("lit_nomatch_lu", 64'(LoadUse), 64'h0);
        set_id(ADD_CTRL, 32'h2, 32'h0, 5'd9, 5'd8, 5'd11);
        #1;
        chk("lit_rtmatch_lu", 64'(LoadUse), 64'h1);
        note("rt match");
        tick(); tick();

        // Flush together with load-use
        set_id(LW_CTRL, 32'h40, 32'h0, 5'd2, 5'd8, 5'd0);
        tick();
        set_id(ADD_CTRL, 32'h3, 32'h0, 5'd8, 5'd1, 5'd12);
        ID_Flush_Branch = 1'b1;
        #1;
        chk("lit_flush_pcw", 64'(PCWrite), 64'h1);
        chk("lit_flush_ifid", 64'(IFID_Write), 64'h1);
        tick(); #1;
        chk("lit_flush_ctrl", 64'(EX_Ctrl), 64'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("lit_flush_bc", 64'(BubbleCount), 64'h2);
`endif
        note("flush");
        ID_Flush_Branch = 1'b0;

        // Hold for 3 cycles with changing inputs, including a hazard condition
        set_id(LW_CTRL, 32'h77, 32'h9, 5'd4, 5'd8, 5'd0);
        tick();
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(ADD_CTRL, 32'h900 + i, 32'h0, 5'd8, 5'(i), 5'd13);
            #1;
            chk("lit_hold_pcw", 64'(PCWrite), 64'h0);
            tick(); #1;
            chk("lit_hold_ctrl", 64'(EX_Ctrl), 64'(LW_CTRL));
            chk("lit_hold_rd1", 64'(EX_RD1), 64'h77);
            note("hold");
        end
        Hold = 1'b0;
        tick(); #1;
        chk("lit_after_hold_ctrl", 64'(EX_Ctrl), 64'h0);
        tick();

        // Reset in the middle of a stall
        set_id(LW_CTRL, 32'h50, 32'h0, 5'd2, 5'd8, 5'd0);
        tick();
        set_id(ADD_CTRL, 32'h5, 32'h0, 5'd8, 5'd3, 5'd14);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("lit_rst_stall_lu", 64'(LoadUse), 64'h0);
        chk("lit_rst_stall_pcw", 64'(PCWrite), 64'h1);
        note("reset mid-stall");
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
